frame_buf_wr_arb: RTL



---
 rtl/frame_buf_wr_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/frame_buf_wr_arb.sv
// Frame-granular round-robin write arbiter for the frame buffer's single write port.
// Optional stall-timeout abort is built only when FB_ARB_TIMEOUT_EN is defined.
module frame_buf_wr_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int FRAME_LEN  = 1 << ADDR_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [1:0]            valid,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic [1:0]            gnt,
    output logic                  fb_wr_en_l,
    output logic [DATA_WIDTH-1:0] fb_data,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  abort
);

    localparam int CNT_W = $clog2(FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_GAP
    } state_t;

    state_t                  state, state_nx;
    logic                    last, last_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [1:0]              gnt_nx;
    logic                    wr_en_l_nx;
    logic [DATA_WIDTH-1:0]   data_nx;
    logic                    done_nx;
    logic                    abort_nx;
    logic                    accept;
    logic                    timeout_hit;
    logic                    owner;

    // gnt is one-hot while in XFER, so bit 1 identifies the owner
    assign owner  = gnt[1];
    assign accept = (state == S_XFER) && |(gnt & valid);
    assign busy   = (state != S_IDLE);

`ifdef FB_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall;

    always_ff @(posedge wr_clk) begin
        if (reset || state != S_XFER || accept)
            stall <= '0;
        else
            stall <= stall + 1'b1;
    end

    assign timeout_hit = (state == S_XFER) && !accept && (stall == STALL_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        last_nx    = last;
        cnt_nx     = cnt;
        wr_en_l_nx = 1'b1;
        data_nx    = fb_data;
        done_nx    = 1'b0;
        abort_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    state_nx = S_XFER;
                    cnt_nx   = '0;
                    case (req)
                        2'b01:   gnt_nx = 2'b01;
                        2'b10:   gnt_nx = 2'b10;
                        default: gnt_nx = last ? 2'b01 : 2'b10;
                    endcase
                end
            end
            S_XFER: begin
                if (accept) begin
                    wr_en_l_nx = 1'b0;
                    data_nx    = owner ? data1 : data0;
                    cnt_nx     = cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_nx = S_GAP;
                        gnt_nx   = 2'b00;
                        done_nx  = 1'b1;
                        last_nx  = owner;
                        cnt_nx   = '0;
                    end
                end else if (timeout_hit) begin
                    state_nx = S_GAP;
                    gnt_nx   = 2'b00;
                    abort_nx = 1'b1;
                    last_nx  = owner;
                    cnt_nx   = '0;
                end
            end
            S_GAP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                gnt_nx   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state      <= S_IDLE;
            gnt        <= 2'b00;
            last       <= 1'b1;
            cnt        <= '0;
            fb_wr_en_l <= 1'b1;
            fb_data    <= '0;
            frame_done <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state      <= state_nx;
            gnt        <= gnt_nx;
            last       <= last_nx;
            cnt        <= cnt_nx;
            fb_wr_en_l <= wr_en_l_nx;
            fb_data    <= data_nx;
            frame_done <= done_nx;
            abort      <= abort_nx;
        end
    end

endmodule
